// File: rtl/seq_det_param.sv
// Parametrised sliding-window serial pattern detector with overlap control and saturating match counter.
// Optional runtime-programmable pattern when SEQDET_PROG_EN is defined.
module seq_det_param #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1001,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seqIn,
    input  logic                 seqValid,
    input  logic                 cntClr,
`ifdef SEQDET_PROG_EN
    input  logic                 patLoad,
    input  logic [PATTERN_W-1:0] patIn,
`endif
    output logic                 detOut,
    output logic [CNT_W-1:0]     matchCnt
);

    localparam int                FILL_W   = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PATTERN_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PATTERN_W-1:0] hist;
    logic [PATTERN_W-1:0] win;
    logic [PATTERN_W-1:0] pat;
    logic [FILL_W-1:0]    fill;
    logic                 load;
    logic                 accept;
    logic                 match;

`ifdef SEQDET_PROG_EN
    assign load = patLoad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat <= PATTERN;
        end else if (patLoad) begin
            pat <= patIn;
        end
    end
`else
    assign load = 1'b0;
    assign pat  = PATTERN;
`endif

    // A pattern load steals the cycle, so any bit offered alongside it is dropped.
    assign accept = seqValid && !load;
    assign win    = {hist[PATTERN_W-2:0], seqIn};
    assign match  = accept && (fill >= FILL_THR) && (win == pat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist   <= '0;
            fill   <= '0;
            detOut <= 1'b0;
        end else if (load) begin
            fill   <= '0;
            detOut <= 1'b0;
        end else if (accept) begin
            hist   <= win;
            detOut <= match;
            if (!OVERLAP && match) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Clear outranks a coincident match; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            matchCnt <= '0;
        end else if (cntClr) begin
            matchCnt <= '0;
        end else if (match && (matchCnt != CNT_MAX)) begin
            matchCnt <= matchCnt + 1'b1;
        end
    end

endmodule
